// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR word server.
package lfsr_pkg;

    localparam int LFSR_W = 18;
    localparam int TAP_HI = 18;
    localparam int TAP_LO = 11;
    localparam logic [LFSR_W-1:0] LFSR_RESET = 18'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Feedback bit of the Fibonacci LFSR: m[TAP_HI] ^ m[TAP_LO].
    // Vector bit k-1 holds LFSR stage m[k].
    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] m);
        return m[TAP_HI-1] ^ m[TAP_LO-1];
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// 18-bit Fibonacci LFSR register with load and step controls.
// Load wins over step; the caller is responsible for never loading zero.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic              bit_out
);

    logic [LFSR_W-1:0] lfsr_r;
    logic              fb_s;

    assign fb_s    = lfsr_feedback(lfsr_r);
    assign state   = lfsr_r;
    assign bit_out = lfsr_r[TAP_HI-1];

    // LFSR state register: reset, load, single step, or hold.
    always_ff @(posedge clock) begin
        if (clear) begin
            lfsr_r <= LFSR_RESET;
        end else if (load) begin
            lfsr_r <= load_val;
        end else if (step) begin
            lfsr_r <= {lfsr_r[LFSR_W-2:0], fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/lfsr_word_server.sv
// Round-robin server handing out WORD_W-bit words from one shared LFSR.
// Each accepted request shifts the LFSR WORD_W times (MSB first) and
// delivers the word with a one-cycle valid/grant pulse.
module lfsr_word_server
    import lfsr_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    word_valid,
    output logic [WORD_W-1:0]       word_data,
    output logic [$clog2(NREQ)-1:0] word_owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(WORD_W - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [OW-1:0]   OWNER_RST = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);

    state_t            state_r;
    state_t            state_nx_s;
    logic [CW-1:0]     cnt_r;
    logic [OW-1:0]     owner_r;
    logic [OW-1:0]     last_owner_r;
    logic [OW-1:0]     winner_s;
    logic [WORD_W-1:0] word_r;
    logic [WORD_W:0]   word_shift_s;
    logic [NREQ-1:0]   gnt_r;
    logic              valid_r;
    logic              busy_r;
    logic              accept_s;
    logic              step_s;
    logic              load_s;
    logic [LFSR_W-1:0] load_val_s;
    logic [LFSR_W-1:0] lfsr_state_s;
    logic              lfsr_bit_s;

    // First set request bit at or after last+1, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 32'sd1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && r[idx[OW-1:0]]) begin
                pick  = idx[OW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    lfsr_core u_core (
        .clock    (clock),
        .clear    (clear),
        .step     (step_s),
        .load     (load_s),
        .load_val (load_val_s),
        .state    (lfsr_state_s),
        .bit_out  (lfsr_bit_s)
    );

    assign word_shift_s = {word_r, lfsr_bit_s};
    assign step_s       = (state_r == SHIFT);

    // Next-state decode and request acceptance.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        winner_s   = rr_pick(req, last_owner_r);
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_nx_s = SHIFT;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Seed loading with zero-seed substitution; a corrupted all-zero LFSR
    // is also recovered here so the generator can never lock up.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = LFSR_RESET;
        if (lfsr_state_s == {LFSR_W{1'b0}}) begin
            load_s     = 1'b1;
            load_val_s = LFSR_RESET;
        end else if ((state_r == IDLE) && seed_load) begin
            load_s = 1'b1;
            if (seed_in == {LFSR_W{1'b0}}) begin
                load_val_s = LFSR_RESET;
            end else begin
                load_val_s = seed_in;
            end
        end else begin
            load_s     = 1'b0;
            load_val_s = LFSR_RESET;
        end
    end

    // FSM, counter, round-robin pointer, word register and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            owner_r      <= {OW{1'b0}};
            last_owner_r <= OWNER_RST;
            word_r       <= {WORD_W{1'b0}};
            gnt_r        <= {NREQ{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            valid_r <= (state_nx_s == DONE);
            busy_r  <= (state_nx_s != IDLE);
            if (state_nx_s == DONE) begin
                gnt_r <= GNT_ONE << owner_r;
            end else begin
                gnt_r <= {NREQ{1'b0}};
            end
            if (accept_s) begin
                owner_r      <= winner_s;
                last_owner_r <= winner_s;
                word_r       <= {WORD_W{1'b0}};
                cnt_r        <= {CW{1'b0}};
            end else if (state_r == SHIFT) begin
                word_r <= word_shift_s[WORD_W-1:0];
                cnt_r  <= cnt_r + CNT_ONE;
            end else begin
                word_r <= word_r;
                cnt_r  <= cnt_r;
            end
        end
    end

    assign gnt        = gnt_r;
    assign word_valid = valid_r;
    assign word_data  = word_r;
    assign word_owner = owner_r;
    assign busy       = busy_r;

endmodule
